// File: rtl/icache_refill_responder.sv
// Memory-side responder for I$ refills: one line-aligned burst per acquire, beats assembled into
// a full line and returned as a single-cycle grant, with coherence invalidates forwarded to the I$.
module icache_refill_responder #(
   parameter int unsigned PADDR_W    = 40,
   parameter int unsigned LINE_W     = 512,
   parameter int unsigned MEM_DATA_W = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  acquire_valid_i,
   input  logic [PADDR_W-1:0]    acquire_paddr_i,
   output logic                  grant_valid_o,
   output logic [LINE_W-1:0]     grant_data_o,
   output logic [1:0]            grant_addr_beat_o,
   output logic                  grant_inval_o,
   output logic [11:0]           grant_inval_addr_o,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic [PADDR_W-1:0]    mem_req_addr_o,
   input  logic                  mem_rsp_valid_i,
   input  logic [MEM_DATA_W-1:0] mem_rsp_data_i,
   input  logic                  mem_rsp_err_i,
   input  logic                  inval_valid_i,
   input  logic [PADDR_W-1:0]    inval_addr_i,
   output logic                  busy_o,
   output logic                  overflow_o,
   output logic                  err_o
);

   localparam int unsigned BEATS = LINE_W / MEM_DATA_W;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned OFF_W = $clog2(LINE_W / 8);
   localparam logic [PADDR_W-1:0] LINE_MASK = {{(PADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

   typedef enum logic [1:0] {StIdle, StReq, StCollect, StGrant} state_e;

   state_e                state_q, state_d;
   logic [PADDR_W-1:0]    addr_q;
   logic                  pend_valid_q;
   logic [PADDR_W-1:0]    pend_addr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [MEM_DATA_W-1:0] beat_q [BEATS-1];
   logic [LINE_W-1:0]     grant_data_q;
   logic                  stale_q, replay_q;
   logic [11:0]           replay_addr_q;
   logic                  inv_valid_q;
   logic [11:0]           inv_addr_q;
   logic                  overflow_q, err_q;

   logic                  latch, acq_held, beat_fire, last_beat, stale_hit;
   logic [PADDR_W-1:0]    sel_addr;
   logic [MEM_DATA_W-1:0] beat_data;

   always_comb begin
      latch     = (state_q == StIdle) && (pend_valid_q || acquire_valid_i);
      sel_addr  = pend_valid_q ? pend_addr_q : acquire_paddr_i;
      // An acquire not taken directly this cycle goes to the pending slot
      acq_held  = acquire_valid_i && ((state_q != StIdle) || pend_valid_q);
      beat_fire = (state_q == StCollect) && mem_rsp_valid_i;
      last_beat = beat_fire && (cnt_q == CNT_W'(BEATS - 1));
      beat_data = mem_rsp_err_i ? '0 : mem_rsp_data_i;
      stale_hit = inval_valid_i && ((state_q == StReq) || (state_q == StCollect)) &&
                  (((inval_addr_i ^ addr_q) & LINE_MASK) == '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (pend_valid_q || acquire_valid_i) state_d = StReq;
         StReq:     if (mem_req_ready_i) state_d = StCollect;
         StCollect: if (last_beat) state_d = StGrant;
         StGrant:   state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o          = (state_q != StIdle);
      mem_req_valid_o = (state_q == StReq);
      grant_valid_o   = (state_q == StGrant);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         if (latch) begin
            addr_q <= sel_addr & LINE_MASK;
         end
         if (latch && pend_valid_q) begin
            pend_valid_q <= 1'b0;
         end
         if (acq_held) begin
            if (pend_valid_q && (state_q != StIdle)) begin
               overflow_q <= 1'b1;
            end else begin
               pend_valid_q <= 1'b1;
               pend_addr_q  <= acquire_paddr_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         err_q        <= 1'b0;
         grant_data_q <= '0;
         for (int i = 0; i < BEATS - 1; i++) beat_q[i] <= '0;
      end else begin
         if ((state_q == StReq) && mem_req_ready_i) begin
            cnt_q <= '0;
         end else if (beat_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (beat_fire && mem_rsp_err_i) begin
            err_q <= 1'b1;
         end
         for (int i = 0; i < BEATS - 1; i++) begin
            if (beat_fire && (cnt_q == CNT_W'(i))) beat_q[i] <= beat_data;
         end
         // Output line only changes when a new one completes
         if (last_beat) begin
            for (int i = 0; i < BEATS - 1; i++) begin
               grant_data_q[i*MEM_DATA_W +: MEM_DATA_W] <= beat_q[i];
            end
            grant_data_q[(BEATS-1)*MEM_DATA_W +: MEM_DATA_W] <= beat_data;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stale_q       <= 1'b0;
         replay_q      <= 1'b0;
         replay_addr_q <= '0;
         inv_valid_q   <= 1'b0;
         inv_addr_q    <= '0;
      end else begin
         inv_valid_q <= inval_valid_i;
         inv_addr_q  <= inval_addr_i[15:4];
         if (latch) begin
            stale_q <= 1'b0;
         end else if (stale_hit) begin
            stale_q <= 1'b1;
         end
         // External invalidates win; replay waits for a free slot
         if ((state_q == StGrant) && stale_q) begin
            replay_q      <= 1'b1;
            replay_addr_q <= addr_q[15:4];
         end else if (replay_q && !inv_valid_q) begin
            replay_q <= 1'b0;
         end
      end
   end

   assign grant_inval_o      = inv_valid_q || replay_q;
   assign grant_inval_addr_o = inv_valid_q ? inv_addr_q : replay_addr_q;
   assign grant_data_o       = grant_data_q;
   assign grant_addr_beat_o  = 2'b00;
   assign mem_req_addr_o     = addr_q;
   assign overflow_o         = overflow_q;
   assign err_o              = err_q;

endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed bench for icache_refill_responder: refill latency, pending/overflow, backpressure,
// error beats, stale-line replay and mid-burst reset.
module tb_icache_refill_responder;

   localparam int unsigned PADDR_W = 40;
   localparam int unsigned LINE_W  = 512;
   localparam int unsigned MDW     = 64;

   logic               clk;
   logic               rst_i;
   logic               acquire_valid_i;
   logic [PADDR_W-1:0] acquire_paddr_i;
   logic               grant_valid_o;
   logic [LINE_W-1:0]  grant_data_o;
   logic [1:0]         grant_addr_beat_o;
   logic               grant_inval_o;
   logic [11:0]        grant_inval_addr_o;
   logic               mem_req_valid_o;
   logic               mem_req_ready_i;
   logic [PADDR_W-1:0] mem_req_addr_o;
   logic               mem_rsp_valid_i;
   logic [MDW-1:0]     mem_rsp_data_i;
   logic               mem_rsp_err_i;
   logic               inval_valid_i;
   logic [PADDR_W-1:0] inval_addr_i;
   logic               busy_o;
   logic               overflow_o;
   logic               err_o;

   int total  = 0;
   int passed = 0;
   int grant_cnt = 0;

   icache_refill_responder #(
      .PADDR_W   (PADDR_W),
      .LINE_W    (LINE_W),
      .MEM_DATA_W(MDW)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .acquire_valid_i   (acquire_valid_i),
      .acquire_paddr_i   (acquire_paddr_i),
      .grant_valid_o     (grant_valid_o),
      .grant_data_o      (grant_data_o),
      .grant_addr_beat_o (grant_addr_beat_o),
      .grant_inval_o     (grant_inval_o),
      .grant_inval_addr_o(grant_inval_addr_o),
      .mem_req_valid_o   (mem_req_valid_o),
      .mem_req_ready_i   (mem_req_ready_i),
      .mem_req_addr_o    (mem_req_addr_o),
      .mem_rsp_valid_i   (mem_rsp_valid_i),
      .mem_rsp_data_i    (mem_rsp_data_i),
      .mem_rsp_err_i     (mem_rsp_err_i),
      .inval_valid_i     (inval_valid_i),
      .inval_addr_i      (inval_addr_i),
      .busy_o            (busy_o),
      .overflow_o        (overflow_o),
      .err_o             (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_i && grant_valid_o) grant_cnt <= grant_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_acquire(input logic [PADDR_W-1:0] a);
      acquire_valid_i = 1'b1;
      acquire_paddr_i = a;
      tick();
      acquire_valid_i = 1'b0;
   endtask

   // Drives 8 beats starting in the current cycle; returns in the cycle after the last beat.
   task automatic send_beats(input logic [63:0] base, input int gap, input int err_idx);
      for (int i = 0; i < 8; i++) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = base + 64'(i);
         mem_rsp_err_i   = (i == err_idx);
         tick();
         if (gap != 0 && i < 7) begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_err_i   = 1'b0;
            tick();
         end
      end
      mem_rsp_valid_i = 1'b0;
      mem_rsp_err_i   = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
      total++; if (grant_valid_o !== 1'b0) $display("FAIL reset_grant: got %b want 0", grant_valid_o); else passed++;
      total++; if (grant_data_o !== '0) $display("FAIL reset_data: got %h want 0", grant_data_o); else passed++;
      total++; if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== '0)
         $display("FAIL reset_req: got %b/%h want 0/0", mem_req_valid_o, mem_req_addr_o); else passed++;
      total++; if (grant_inval_o !== 1'b0 || grant_inval_addr_o !== 12'h0)
         $display("FAIL reset_inval: got %b/%h want 0/000", grant_inval_o, grant_inval_addr_o); else passed++;
      total++; if (overflow_o !== 1'b0 || err_o !== 1'b0 || grant_addr_beat_o !== 2'b00)
         $display("FAIL reset_flags: got ovf %b err %b beat %b want 0 0 00", overflow_o, err_o, grant_addr_beat_o);
      else passed++;
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_single();
      mem_req_ready_i = 1'b1;
      do_acquire(40'h00_8000_0044);
      total++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 40'h00_8000_0040)
         $display("FAIL single_req: got %b/%h want 1/0080000040", mem_req_valid_o, mem_req_addr_o); else passed++;
      tick();
      total++; if (grant_valid_o !== 1'b0) $display("FAIL single_early_grant: got %b want 0", grant_valid_o); else passed++;
      send_beats(64'h1111_0000, 0, -1);
      total++; if (grant_valid_o !== 1'b1) $display("FAIL single_grant_t10: got %b want 1", grant_valid_o); else passed++;
      total++; if (grant_data_o[63:0] !== 64'h1111_0000)
         $display("FAIL single_beat0: got %h want 11110000", grant_data_o[63:0]); else passed++;
      total++; if (grant_data_o[191:128] !== 64'h1111_0002)
         $display("FAIL single_beat2: got %h want 11110002", grant_data_o[191:128]); else passed++;
      total++; if (grant_data_o[511:448] !== 64'h1111_0007)
         $display("FAIL single_beat7: got %h want 11110007", grant_data_o[511:448]); else passed++;
      tick();
      total++; if (grant_valid_o !== 1'b0 || busy_o !== 1'b0)
         $display("FAIL single_after: got grant %b busy %b want 0 0", grant_valid_o, busy_o); else passed++;
      total++; if (grant_data_o[511:448] !== 64'h1111_0007)
         $display("FAIL single_hold: got %h want 11110007", grant_data_o[511:448]); else passed++;
   endtask

   task automatic test_back_to_back();
      mem_req_ready_i = 1'b0;
      do_acquire(40'h00_1000_0000);
      do_acquire(40'h00_2000_00A4);
      total++; if (overflow_o !== 1'b0) $display("FAIL b2b_ovf_early: got %b want 0", overflow_o); else passed++;
      do_acquire(40'h00_3000_0100);
      total++; if (overflow_o !== 1'b1) $display("FAIL b2b_overflow: got %b want 1", overflow_o); else passed++;
      total++; if (mem_req_addr_o !== 40'h00_1000_0000)
         $display("FAIL b2b_addr_a: got %h want 0010000000", mem_req_addr_o); else passed++;
      mem_req_ready_i = 1'b1;
      tick();
      send_beats(64'hA000_0000, 0, -1);
      total++; if (grant_valid_o !== 1'b1 || grant_data_o[63:0] !== 64'hA000_0000)
         $display("FAIL b2b_grant_a: got %b/%h want 1/a0000000", grant_valid_o, grant_data_o[63:0]); else passed++;
      tick();
      total++; if (busy_o !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy_o); else passed++;
      tick();
      total++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 40'h00_2000_0080)
         $display("FAIL b2b_req_b: got %b/%h want 1/0020000080", mem_req_valid_o, mem_req_addr_o); else passed++;
      tick();
      send_beats(64'hB000_0000, 0, -1);
      total++; if (grant_valid_o !== 1'b1 || grant_data_o[511:448] !== 64'hB000_0007)
         $display("FAIL b2b_grant_b: got %b/%h want 1/b0000007", grant_valid_o, grant_data_o[511:448]); else passed++;
      tick();
      tick();
      tick();
      total++; if (busy_o !== 1'b0 || mem_req_valid_o !== 1'b0)
         $display("FAIL b2b_c_dropped: got busy %b req %b want 0 0", busy_o, mem_req_valid_o); else passed++;
   endtask

   task automatic test_backpressure();
      int g0;
      g0 = grant_cnt;
      mem_req_ready_i = 1'b0;
      do_acquire(40'h00_4000_01C8);
      for (int i = 0; i < 5; i++) begin
         total++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 40'h00_4000_01C0)
            $display("FAIL bp_stable_%0d: got %b/%h want 1/00400001c0", i, mem_req_valid_o, mem_req_addr_o);
         else passed++;
         tick();
      end
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0;
      send_beats(64'h5555_0000, 1, -1);
      total++; if (grant_valid_o !== 1'b1 || grant_data_o[63:0] !== 64'h5555_0000)
         $display("FAIL bp_grant: got %b/%h want 1/55550000", grant_valid_o, grant_data_o[63:0]); else passed++;
      total++; if (grant_data_o[511:448] !== 64'h5555_0007)
         $display("FAIL bp_beat7: got %h want 55550007", grant_data_o[511:448]); else passed++;
      tick();
      tick();
      total++; if (grant_cnt - g0 !== 1) $display("FAIL bp_one_grant: got %0d want 1", grant_cnt - g0);
      else passed++;
   endtask

   task automatic test_error();
      mem_req_ready_i = 1'b1;
      do_acquire(40'h00_6000_0000);
      tick();
      send_beats(64'h2222_0000, 0, 3);
      total++; if (grant_valid_o !== 1'b1 || grant_data_o[255:192] !== 64'h0)
         $display("FAIL err_beat3: got %b/%h want 1/0", grant_valid_o, grant_data_o[255:192]); else passed++;
      total++; if (grant_data_o[191:128] !== 64'h2222_0002 || grant_data_o[319:256] !== 64'h2222_0004)
         $display("FAIL err_neighbours: got %h %h want 22220002 22220004",
                  grant_data_o[191:128], grant_data_o[319:256]); else passed++;
      total++; if (err_o !== 1'b1) $display("FAIL err_flag: got %b want 1", err_o); else passed++;
      tick();
   endtask

   task automatic test_stale();
      total++; if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else passed++;
      mem_req_ready_i = 1'b1;
      do_acquire(40'h00_8000_0040);
      tick();
      for (int i = 0; i < 8; i++) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = 64'h7777_0000 + 64'(i);
         inval_valid_i   = (i == 2);
         inval_addr_i    = 40'h00_8000_0040;
         tick();
         if (i == 2) begin
            total++; if (grant_inval_o !== 1'b1 || grant_inval_addr_o !== 12'h004)
               $display("FAIL stale_immediate: got %b/%h want 1/004", grant_inval_o, grant_inval_addr_o);
            else passed++;
         end
      end
      mem_rsp_valid_i = 1'b0;
      inval_valid_i   = 1'b1;
      inval_addr_i    = 40'h00_1234_5670;
      total++; if (grant_valid_o !== 1'b1 || grant_inval_o !== 1'b0)
         $display("FAIL stale_grant: got grant %b inval %b want 1 0", grant_valid_o, grant_inval_o); else passed++;
      tick();
      inval_valid_i = 1'b0;
      total++; if (grant_inval_o !== 1'b1 || grant_inval_addr_o !== 12'h567)
         $display("FAIL stale_external: got %b/%h want 1/567", grant_inval_o, grant_inval_addr_o); else passed++;
      tick();
      total++; if (grant_inval_o !== 1'b1 || grant_inval_addr_o !== 12'h004)
         $display("FAIL stale_replay: got %b/%h want 1/004", grant_inval_o, grant_inval_addr_o); else passed++;
      tick();
      total++; if (grant_inval_o !== 1'b0) $display("FAIL stale_done: got %b want 0", grant_inval_o); else passed++;
   endtask

   task automatic test_reset_mid();
      int g0;
      mem_req_ready_i = 1'b1;
      do_acquire(40'h00_9000_0000);
      tick();
      for (int i = 0; i < 5; i++) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = 64'h9999_0000 + 64'(i);
         tick();
      end
      mem_rsp_valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      total++; if (busy_o !== 1'b0 || grant_data_o !== '0 || mem_req_valid_o !== 1'b0)
         $display("FAIL rstmid_outputs: got busy %b data %h req %b want 0 0 0",
                  busy_o, grant_data_o[63:0], mem_req_valid_o); else passed++;
      total++; if (err_o !== 1'b0 || overflow_o !== 1'b0)
         $display("FAIL rstmid_sticky: got err %b ovf %b want 0 0", err_o, overflow_o); else passed++;
      tick();
      rst_i = 1'b0;
      g0 = grant_cnt;
      for (int i = 0; i < 3; i++) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = 64'h9999_0005 + 64'(i);
         tick();
      end
      mem_rsp_valid_i = 1'b0;
      tick();
      total++; if (busy_o !== 1'b0 || grant_cnt - g0 !== 0)
         $display("FAIL rstmid_leftover: got busy %b grants %0d want 0 0", busy_o, grant_cnt - g0); else passed++;
      do_acquire(40'h00_A000_0040);
      total++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 40'h00_A000_0040)
         $display("FAIL rstmid_req: got %b/%h want 1/00a0000040", mem_req_valid_o, mem_req_addr_o); else passed++;
      tick();
      send_beats(64'h3333_0000, 0, -1);
      total++; if (grant_valid_o !== 1'b1 || grant_data_o[63:0] !== 64'h3333_0000 ||
                   grant_data_o[511:448] !== 64'h3333_0007)
         $display("FAIL rstmid_next: got %b/%h/%h want 1/33330000/33330007",
                  grant_valid_o, grant_data_o[63:0], grant_data_o[511:448]); else passed++;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_i           = 1'b1;
      acquire_valid_i = 1'b0;
      acquire_paddr_i = '0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
      mem_rsp_err_i   = 1'b0;
      inval_valid_i   = 1'b0;
      inval_addr_i    = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_error();
      test_stale();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
